jtcop_gfx_romslot: RTL
======================

JTCOP_GFX_ROMSLOT -- requirements
Module: jtcop_gfx_romslot

Interface
REQ-001 Parameter OFFSET, default 22'h0: 16-bit word base address of this graphics ROM region in SDRAM.
REQ-002 Parameter HOLD_REQ, default 1: when 1, sdram_req stays high until sdram_ack; when 0, it is a one-cycle pulse.
REQ-003 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high.
REQ-004 clk  input  1  system clock (48 MHz); all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 rom_cs  input  1  tile engine requests the word at rom_addr.
REQ-007 rom_addr  input  19  32-bit word address; top 2 bits are NCGSEL[1:0].
REQ-008 rom_data  output  32  fetched word, valid when rom_ok=1.
REQ-009 rom_ok  output  1  rom_data matches the current rom_addr.
REQ-010 sdram_req  output  1  fetch request to the SDRAM arbiter.
REQ-011 sdram_addr  output  22  16-bit word address of the fetch.
REQ-012 sdram_ack  input  1  arbiter accepted the request.
REQ-013 sdram_dok  input  1  a 16-bit data beat is present on sdram_data.
REQ-014 sdram_data  input  16  SDRAM read data.

Function
REQ-015 The block SHALL hold a single-entry cache: tag[18:0], data[31:0] and valid.
REQ-016 rom_ok SHALL be rom_cs & valid & (tag==rom_addr), combinational from registered state; rom_data SHALL be the cache data.
REQ-017 The FSM SHALL have four states: IDLE, REQ, WAIT_LO and WAIT_HI.
REQ-018 IDLE: if rom_cs=1 and it is a miss, the FSM SHALL latch rom_addr into pend_addr and go to REQ; otherwise it SHALL stay in IDLE.
REQ-019 REQ: sdram_req=1 and sdram_addr=OFFSET+{pend_addr,1'b0}, truncated to 22 bits (wrap-around allowed).
- On sdram_ack=1, the FSM SHALL go to WAIT_LO.
- sdram_req SHALL be 0 from the cycle after ack.
REQ-020 HOLD_REQ=0: sdram_req SHALL be high only on the first REQ cycle.
- The FSM SHALL still wait in REQ for sdram_ack.
REQ-021 sdram_dok SHALL be ignored in IDLE and REQ, including in the same cycle as sdram_ack.
REQ-022 WAIT_LO: on sdram_dok, the FSM SHALL capture sdram_data into the low half of a staging register and go to WAIT_HI.
REQ-023 WAIT_HI: on sdram_dok, the FSM SHALL write {sdram_data, staging_low} to cache data and pend_addr to tag.
- valid SHALL be set to 1 and the FSM SHALL go to IDLE.
- rom_ok SHALL be visible the next cycle if rom_addr still equals pend_addr.
REQ-024 Changes to rom_addr or rom_cs during REQ, WAIT_LO or WAIT_HI SHALL NOT abort the fetch.
- The fetch SHALL complete and fill the cache.
- A new miss SHALL be detected in IDLE on the following cycle.
REQ-025 When rom_cs=0, rom_ok SHALL be 0 and no new fetch SHALL start.
- A fetch already in flight SHALL complete.
REQ-026 Minimum miss latency: 1 cycle IDLE→REQ, then ack and two dok beats, then rom_ok on the cycle after the second beat.
REQ-027 There SHALL be no back-to-back prefetch; only one outstanding SDRAM request at a time.

Reset
REQ-028 While rst=1: FSM=IDLE, valid=0, tag=0, cache data=0, staging=0, sdram_req=0, sdram_addr=0, and hence rom_ok=0.
REQ-029 rst asserted mid-fetch SHALL abandon the fetch immediately, with no cache update.
- Beats arriving after reset release SHALL be ignored (state is IDLE).

Verification
REQ-030 Miss-then-hit, OFFSET=22'h10_0000.
- Stimulus: rom_cs=1, rom_addr=19'h00123; ack 2 cycles after req; dok beats 16'hBEEF then 16'hDEAD.
- Required: sdram_addr=22'h10_0246; rom_data=32'hDEADBEEF with rom_ok=1 the cycle after the 2nd beat.
- Required: no further sdram_req while rom_addr is held.
REQ-031 Address change mid-fetch.
- Stimulus: rom_addr switches from 19'h00010 to 19'h00011 while in WAIT_LO.
- Required: the first fetch completes with tag=19'h00010 and rom_ok=0.
- Required: a second request with sdram_addr=OFFSET+22'h22 follows, then rom_ok=1.
REQ-032 rom_cs drop.
- Stimulus: rom_cs falls in REQ.
- Required: req is held until ack, both beats are consumed and valid=1.
- Required: rom_cs re-asserted with the same address gives rom_ok=1 with no new request.
REQ-033 Reset mid-operation.
- Stimulus: rst pulse in WAIT_HI, then a stray dok.
- Required: rom_ok=0, sdram_req=0 and the cache is not written.
REQ-034 HOLD_REQ=0 with ack delayed 5 cycles.
- Required: sdram_req is high for exactly 1 cycle, the FSM leaves REQ only on ack, and the data is correct.
REQ-035 Address wrap.
- Stimulus: OFFSET=22'h3F_FFFE, rom_addr=19'h00001.
- Required: sdram_addr=22'h00_0000.

Source files
------------

// File: rtl/jtcop_gfx_romslot.sv
// Single-entry graphics ROM cache that turns 32-bit tile fetches into two
// 16-bit SDRAM beats (low half first).
//
// Parameters
//   OFFSET     16-bit word base address of this ROM region in SDRAM
//   HOLD_REQ   1: sdram_req held until sdram_ack, 0: one-cycle request pulse
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   rom_cs, rom_addr[18:0]      tile engine word request (32-bit word address)
//   rom_data[31:0], rom_ok      cached word and hit indication (rom_ok is
//                               combinational from registered cache state)
//   sdram_req, sdram_addr[21:0] fetch request and 16-bit word address
//   sdram_ack                   arbiter accepted the request
//   sdram_dok, sdram_data[15:0] read data beat strobe and data
module jtcop_gfx_romslot #(
  parameter logic [21:0] OFFSET   = 22'h0,
  parameter bit          HOLD_REQ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_cs,
  input  logic [18:0] rom_addr,
  output logic [31:0] rom_data,
  output logic        rom_ok,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_dok,
  input  logic [15:0] sdram_data
);

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 16;
  localparam int unsigned SW = 22;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_LO = 2'd2,
    ST_WAIT_HI = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pend_q,  pend_d;
  logic [AW-1:0] tag_q,   tag_d;
  logic [DW-1:0] data_q,  data_d;
  logic          valid_q, valid_d;
  logic [BW-1:0] stage_q, stage_d;
  logic          req_q,   req_d;
  logic [SW-1:0] saddr_q, saddr_d;
  logic          hit_c;

  // Cache lookup against the live request address
  assign hit_c    = valid_q && (tag_q == rom_addr);
  assign rom_ok   = rom_cs && hit_c;
  assign rom_data = data_q;

  assign sdram_req  = req_q;
  assign sdram_addr = saddr_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      stage_q <= '0;
      req_q   <= 1'b0;
      saddr_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      stage_q <= stage_d;
      req_q   <= req_d;
      saddr_q <= saddr_d;
    end
  end

  // Next-state and fetch control
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    stage_d = stage_q;
    req_d   = req_q;
    saddr_d = saddr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rom_cs && !hit_c) begin
          pend_d  = rom_addr;
          // Word address doubled into 16-bit units; sum wraps at 22 bits
          saddr_d = OFFSET + SW'({rom_addr, 1'b0});
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Pulse mode drops the request after its first cycle but still
        // waits here for the acknowledge; data beats are ignored
        req_d = HOLD_REQ && !sdram_ack;
        if (sdram_ack) begin
          state_d = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (sdram_dok) begin
          stage_d = sdram_data;
          state_d = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (sdram_dok) begin
          data_d  = {sdram_data, stage_q};
          tag_d   = pend_q;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
